// File: rtl/i2c_master_monitor_core.sv
// i2c_master_monitor_core
//   Passive I2C bus monitor. Synchronises the raw SCL/SDA lines, detects
//   START / repeated START / STOP, deserialises address and data bytes
//   (including the ACK bit) and queues one event per bus occurrence in a
//   small FIFO read through a valid/ready port.
//
// Optional feature macro: I2C_MASTER_MONITOR_GLITCH_FILTER_EN
//   When defined, each synchronised line passes through a stability filter
//   (FILT_CYCLES consecutive cycles) before edge detection.
//
// Ports
//   pclk          single clock, rising edge
//   areset        synchronous active-low reset
//   scl_i, sda_i  raw bus lines (asynchronous to pclk)
//   enable        monitor enable; 0 forces IDLE and suppresses new events
//   evt_valid/evt_ready  event handshake; evt_type/evt_data/evt_ack = head
//                 entry (type 0 START, 1 RSTART, 2 ADDR, 3 DATA, 4 STOP)
//   fifo_level    occupied FIFO entries
//   overflow      sticky drop flag, cleared by clr_overflow (set wins)
//   bus_busy      1 while between START and STOP
//   dbg_state     FSM state (0 IDLE, 1 ADDR, 2 DATA)
//
// Handshake: an entry transfers on a rising pclk edge where evt_valid and
// evt_ready are both 1; while evt_valid=1 and evt_ready=0 the head outputs
// hold; evt_valid never depends on evt_ready.
module i2c_master_monitor_core #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  logic                        pclk,
  input  logic                        areset,
  input  logic                        scl_i,
  input  logic                        sda_i,
  input  logic                        enable,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [2:0]                  evt_type,
  output logic [7:0]                  evt_data,
  output logic                        evt_ack,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        clr_overflow,
  output logic                        bus_busy,
  output logic [1:0]                  dbg_state
);
  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [2:0] EV_START = 3'd0, EV_RSTART = 3'd1, EV_ADDR = 3'd2,
                         EV_DATA  = 3'd3, EV_STOP   = 3'd4;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} state_t;

  // ---------------- synchroniser ----------------
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_s, sda_s;
  assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
  assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};

`ifdef I2C_MASTER_MONITOR_GLITCH_FILTER_EN
  localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  logic          scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic [FW-1:0] scl_fc_q, scl_fc_d, sda_fc_q, sda_fc_d;

  // Output follows the input only once it has differed for FILT_CYCLES cycles.
  always_comb begin
    scl_f_d  = scl_f_q;
    scl_fc_d = '0;
    if (scl_sync_q[SYNC_STAGES-1] != scl_f_q) begin
      if (scl_fc_q == FW'(FILT_CYCLES-1)) scl_f_d  = scl_sync_q[SYNC_STAGES-1];
      else                                scl_fc_d = scl_fc_q + FW'(1);
    end
    sda_f_d  = sda_f_q;
    sda_fc_d = '0;
    if (sda_sync_q[SYNC_STAGES-1] != sda_f_q) begin
      if (sda_fc_q == FW'(FILT_CYCLES-1)) sda_f_d  = sda_sync_q[SYNC_STAGES-1];
      else                                sda_fc_d = sda_fc_q + FW'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (!areset) begin
      scl_f_q <= 1'b1; sda_f_q <= 1'b1; scl_fc_q <= '0; sda_fc_q <= '0;
    end else begin
      scl_f_q <= scl_f_d; sda_f_q <= sda_f_d; scl_fc_q <= scl_fc_d; sda_fc_q <= sda_fc_d;
    end
  end
  assign scl_s = scl_f_q;
  assign sda_s = sda_f_q;
`else
  logic filt_unused;
  assign filt_unused = (FILT_CYCLES != 0);
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

  // ---------------- edge detection ----------------
  logic scl_p_q, sda_p_q;
  logic scl_rise, start_det, stop_det;
  assign scl_rise  = scl_s & ~scl_p_q;
  assign start_det = enable & scl_s & scl_p_q &  sda_p_q & ~sda_s;
  assign stop_det  = enable & scl_s & scl_p_q & ~sda_p_q &  sda_s;

  // ---------------- FSM ----------------
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  // Counter value before the current SCL-high phase began. A STOP is always
  // preceded by an SCL rise that is not a data bit, so STOP reports this.
  logic [3:0] stop_cnt_q, stop_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       pend_valid_q, pend_valid_d, pend_ack_q, pend_ack_d;
  logic [2:0] pend_type_q, pend_type_d;
  logic [7:0] pend_data_q, pend_data_d;

  always_comb begin
    state_d = state_q;
    if (!enable) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:  if (start_det) state_d = S_ADDR;
        S_ADDR: begin
          if (start_det)                      state_d = S_ADDR;
          else if (stop_det)                  state_d = S_IDLE;
          else if (scl_rise && cnt_q == 4'd8) state_d = S_DATA;
        end
        S_DATA: begin
          if (start_det)     state_d = S_ADDR;
          else if (stop_det) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_busy  = (state_q != S_IDLE);
    dbg_state = state_q;
  end

  // Bit deserialiser and event generation.
  always_comb begin
    cnt_d = cnt_q; stop_cnt_d = stop_cnt_q; shreg_d = shreg_q;
    pend_valid_d = 1'b0; pend_type_d = 3'd0; pend_data_d = 8'd0; pend_ack_d = 1'b0;
    if (!enable) begin
      cnt_d = 4'd0; stop_cnt_d = 4'd0;
    end else if (start_det) begin
      pend_valid_d = 1'b1;
      pend_type_d  = (state_q == S_IDLE) ? EV_START : EV_RSTART;
      cnt_d = 4'd0; stop_cnt_d = 4'd0;
    end else if (state_q != S_IDLE) begin
      if (stop_det) begin
        pend_valid_d = 1'b1;
        pend_type_d  = EV_STOP;
        pend_data_d  = {4'b0, stop_cnt_q};
        cnt_d = 4'd0; stop_cnt_d = 4'd0;
      end else if (scl_rise) begin
        if (cnt_q == 4'd8) begin
          pend_valid_d = 1'b1;
          pend_type_d  = (state_q == S_ADDR) ? EV_ADDR : EV_DATA;
          pend_data_d  = shreg_q;
          pend_ack_d   = ~sda_s;
          cnt_d = 4'd0; stop_cnt_d = 4'd0;
        end else begin
          shreg_d    = {shreg_q[6:0], sda_s};
          stop_cnt_d = cnt_q;
          cnt_d      = cnt_q + 4'd1;
        end
      end
    end
  end

  // ---------------- event FIFO ----------------
  logic [11:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          fifo_pop, fifo_full, fifo_wr;
  logic [11:0]   head;

  assign evt_valid = (count_q != '0);
  assign fifo_pop  = evt_valid & evt_ready;
  assign fifo_full = (count_q == FULL_LVL);
  assign fifo_wr   = pend_valid_q & (~fifo_full | fifo_pop);

  always_comb begin
    wr_ptr_d = fifo_wr  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = fifo_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (fifo_wr && !fifo_pop)      count_d = count_q + LVL_ONE;
    else if (!fifo_wr && fifo_pop) count_d = count_q - LVL_ONE;
    overflow_d = overflow_q;
    if (pend_valid_q && fifo_full && !fifo_pop) overflow_d = 1'b1;
    else if (clr_overflow)                      overflow_d = 1'b0;
  end

  always_ff @(posedge pclk) begin
    if (areset && fifo_wr) mem_q[wr_ptr_q] <= {pend_type_q, pend_data_q, pend_ack_q};
  end

  assign head       = mem_q[rd_ptr_q];
  assign evt_type   = evt_valid ? head[11:9] : 3'd0;
  assign evt_data   = evt_valid ? head[8:1]  : 8'd0;
  assign evt_ack    = evt_valid ? head[0]    : 1'b0;
  assign fifo_level = count_q;
  assign overflow   = overflow_q;

  always_ff @(posedge pclk) begin
    if (!areset) begin
      scl_sync_q <= '1; sda_sync_q <= '1; scl_p_q <= 1'b1; sda_p_q <= 1'b1;
      state_q <= S_IDLE; cnt_q <= 4'd0; stop_cnt_q <= 4'd0; shreg_q <= 8'd0;
      pend_valid_q <= 1'b0; pend_type_q <= 3'd0; pend_data_q <= 8'd0; pend_ack_q <= 1'b0;
      wr_ptr_q <= '0; rd_ptr_q <= '0; count_q <= '0; overflow_q <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d; sda_sync_q <= sda_sync_d; scl_p_q <= scl_s; sda_p_q <= sda_s;
      state_q <= state_d; cnt_q <= cnt_d; stop_cnt_q <= stop_cnt_d; shreg_q <= shreg_d;
      pend_valid_q <= pend_valid_d; pend_type_q <= pend_type_d;
      pend_data_q <= pend_data_d; pend_ack_q <= pend_ack_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d; overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_i2c_master_monitor_core.sv
// Self-checking bench for i2c_master_monitor_core: table of bus operations
// with expected events, plus hand-written latency, overflow, reset, enable
// and (when the filter macro is defined) glitch sequences.
module tb_i2c_master_monitor_core;
  localparam int FIFO_DEPTH = 8;
  localparam int H = 4;  // pclk cycles per SCL half phase
`ifdef I2C_MASTER_MONITOR_GLITCH_FILTER_EN
  localparam int EXP_LAT = 7;
`else
  localparam int EXP_LAT = 4;
`endif
  localparam logic [2:0] EV_START = 3'd0, EV_RSTART = 3'd1, EV_ADDR = 3'd2,
                         EV_DATA  = 3'd3, EV_STOP   = 3'd4;

  logic pclk = 1'b0, areset = 1'b0, scl_i = 1'b1, sda_i = 1'b1;
  logic enable = 1'b0, evt_ready = 1'b0, clr_overflow = 1'b0;
  logic evt_valid, evt_ack, overflow, bus_busy;
  logic [2:0] evt_type;
  logic [7:0] evt_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  i2c_master_monitor_core #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(2), .FILT_CYCLES(3)) dut (
    .pclk(pclk), .areset(areset), .scl_i(scl_i), .sda_i(sda_i), .enable(enable),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
    .evt_data(evt_data), .evt_ack(evt_ack), .fifo_level(fifo_level),
    .overflow(overflow), .clr_overflow(clr_overflow), .bus_busy(bus_busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 pclk = ~pclk;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic i2c_start();
    sda_i = 1'b0; tick(H);
    scl_i = 1'b0; tick(H);
  endtask

  task automatic i2c_rstart();
    sda_i = 1'b1; tick(H);
    scl_i = 1'b1; tick(H);
    sda_i = 1'b0; tick(H);
    scl_i = 1'b0; tick(H);
  endtask

  task automatic i2c_stop();
    scl_i = 1'b0; tick(H);
    sda_i = 1'b0; tick(H);
    scl_i = 1'b1; tick(H);
    sda_i = 1'b1; tick(H);
  endtask

  task automatic send_bit(input logic b);
    sda_i = b;    tick(H);
    scl_i = 1'b1; tick(H);
    scl_i = 1'b0; tick(H);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int b = 0; b < n; b++) send_bit(v[7-b]);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic ack_n);
    send_bits(v, 8);
    send_bit(ack_n);
  endtask

  task automatic pop_evt();
    evt_ready = 1'b1; tick(1);
    evt_ready = 1'b0;
  endtask

  // ---------------- scoreboard helpers ----------------
  function automatic logic [11:0] head();
    return {evt_type, evt_data, evt_ack};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef enum int {OP_START, OP_RSTART, OP_BYTE, OP_BITS, OP_STOP} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] val;
    int         nbits;
    logic       ack_n;
    logic       has_evt;
    logic [2:0] e_type;
    logic [7:0] e_data;
    logic       e_ack;
    logic       e_busy;
  } vec_t;
  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin
    int lat;
    logic got_evt;

    vecs[0]  = '{OP_START,  8'h00, 0, 1'b0, 1'b1, EV_START,  8'h00, 1'b0, 1'b1};
    vecs[1]  = '{OP_BYTE,   8'hA0, 8, 1'b0, 1'b1, EV_ADDR,   8'hA0, 1'b1, 1'b1};
    vecs[2]  = '{OP_BYTE,   8'h5A, 8, 1'b0, 1'b1, EV_DATA,   8'h5A, 1'b1, 1'b1};
    vecs[3]  = '{OP_STOP,   8'h00, 0, 1'b0, 1'b1, EV_STOP,   8'h00, 1'b0, 1'b0};
    vecs[4]  = '{OP_START,  8'h00, 0, 1'b0, 1'b1, EV_START,  8'h00, 1'b0, 1'b1};
    vecs[5]  = '{OP_BYTE,   8'h51, 8, 1'b0, 1'b1, EV_ADDR,   8'h51, 1'b1, 1'b1};
    vecs[6]  = '{OP_RSTART, 8'h00, 0, 1'b0, 1'b1, EV_RSTART, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{OP_BYTE,   8'h51, 8, 1'b1, 1'b1, EV_ADDR,   8'h51, 1'b0, 1'b1};
    vecs[8]  = '{OP_STOP,   8'h00, 0, 1'b0, 1'b1, EV_STOP,   8'h00, 1'b0, 1'b0};
    vecs[9]  = '{OP_START,  8'h00, 0, 1'b0, 1'b1, EV_START,  8'h00, 1'b0, 1'b1};
    vecs[10] = '{OP_BYTE,   8'hC3, 8, 1'b0, 1'b1, EV_ADDR,   8'hC3, 1'b1, 1'b1};
    vecs[11] = '{OP_BITS,   8'hB8, 5, 1'b0, 1'b0, EV_START,  8'h00, 1'b0, 1'b1};
    vecs[12] = '{OP_STOP,   8'h00, 0, 1'b0, 1'b1, EV_STOP,   8'h05, 1'b0, 1'b0};
    vecs[13] = '{OP_STOP,   8'h00, 0, 1'b0, 1'b0, EV_START,  8'h00, 1'b0, 1'b0};

    // ---------------- reset ----------------
    tick(3);
    check("rst_valid", evt_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf",   overflow, 0);
    check("rst_busy",  bus_busy, 0);
    check("rst_head",  head(), 0);
    areset = 1'b1; enable = 1'b1;
    tick(4);

    // ---------------- table ----------------
    for (int i = 0; i < NV; i++) begin
      case (vecs[i].op)
        OP_START:  i2c_start();
        OP_RSTART: i2c_rstart();
        OP_BYTE:   send_byte(vecs[i].val, vecs[i].ack_n);
        OP_BITS:   send_bits(vecs[i].val, vecs[i].nbits);
        default:   i2c_stop();
      endcase
      tick(8);
      check($sformatf("row%0d_level", i), fifo_level, vecs[i].has_evt ? 32'd1 : 32'd0);
      check($sformatf("row%0d_busy", i), bus_busy, vecs[i].e_busy);
      if (vecs[i].has_evt) begin
        check($sformatf("row%0d_evt", i), head(), {vecs[i].e_type, vecs[i].e_data, vecs[i].e_ack});
        pop_evt();
      end
    end

    // ---------------- detection latency ----------------
    @(posedge pclk); #1;
    sda_i = 1'b0;
    lat = 0; got_evt = 1'b0;
    for (int c = 1; c <= 20 && !got_evt; c++) begin
      @(posedge pclk); @(negedge pclk);
      if (evt_valid) begin lat = c; got_evt = 1'b1; end
    end
    check("latency", lat, EXP_LAT);
    check("lat_evt", head(), {EV_START, 8'h00, 1'b0});
    pop_evt();
    i2c_stop(); tick(8);
    check("lat_stop", head(), {EV_STOP, 8'h00, 1'b0});
    pop_evt();
    check("lat_idle", bus_busy, 0);

    // ---------------- overflow ----------------
    i2c_start();                 exp_q.push_back({EV_START, 8'h00, 1'b0});
    send_byte(8'h10, 1'b0);      exp_q.push_back({EV_ADDR,  8'h10, 1'b1});
    for (int k = 0; k < 7; k++) begin
      send_byte(8'h21 + 8'(k), 1'b0);
      if (k < 6) exp_q.push_back({EV_DATA, 8'h21 + 8'(k), 1'b1});
    end
    i2c_stop(); tick(8);
    check("ovf_level", fifo_level, FIFO_DEPTH);
    check("ovf_flag", overflow, 1);
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      check($sformatf("drain%0d", k), head(), exp_q.pop_front());
      pop_evt();
    end
    check("drain_empty", evt_valid, 0);
    check("ovf_sticky", overflow, 1);
    clr_overflow = 1'b1; tick(1); clr_overflow = 1'b0;
    check("ovf_clr", overflow, 0);

    // ---------------- reset mid-byte ----------------
    i2c_start();
    send_byte(8'h3C, 1'b0);
    send_byte(8'h96, 1'b0);
    tick(8);
    check("rq_level", fifo_level, 3);
    send_bits(8'hE0, 3);
    areset = 1'b0; tick(1);
    check("rq_valid", evt_valid, 0);
    check("rq_level0", fifo_level, 0);
    check("rq_busy", bus_busy, 0);
    areset = 1'b1;
    i2c_stop(); tick(10);
    check("rq_nostop", fifo_level, 0);

    // ---------------- enable ----------------
    enable = 1'b0;
    i2c_start();
    send_byte(8'h77, 1'b0);
    tick(8);
    check("dis_level", fifo_level, 0);
    check("dis_busy", bus_busy, 0);
    enable = 1'b1;
    send_byte(8'h12, 1'b0);
    i2c_stop(); tick(8);
    check("en_wait_start", fifo_level, 0);
    i2c_start(); tick(8);
    check("en_start", head(), {EV_START, 8'h00, 1'b0});
    check("en_busy", bus_busy, 1);
    pop_evt();
    i2c_stop(); tick(8);
    check("en_stop", head(), {EV_STOP, 8'h00, 1'b0});
    pop_evt();

`ifdef I2C_MASTER_MONITOR_GLITCH_FILTER_EN
    // ---------------- glitch filter ----------------
    tick(4);
    sda_i = 1'b0; tick(2); sda_i = 1'b1; tick(12);
    check("glitch2_level", fifo_level, 0);
    sda_i = 1'b0; tick(4); sda_i = 1'b1; tick(14);
    check("glitch4_level", fifo_level, 2);
    check("glitch4_start", head(), {EV_START, 8'h00, 1'b0});
    pop_evt();
    check("glitch4_stop", head(), {EV_STOP, 8'h00, 1'b0});
    pop_evt();
`endif

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_master_monitor_core.md
I2C_MASTER_MONITOR_CORE -- requirements
Module: i2c_master_monitor_core

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries; power of 2, minimum 2.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser flops on scl_i/sda_i; minimum 2.
REQ-003 SHALL have parameter FILT_CYCLES, default 3, glitch-filter stability count (used only per REQ-024).
REQ-004 SHALL have port pclk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port areset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports scl_i, sda_i  input  1 each  raw bus lines, asynchronous to pclk.
REQ-007 SHALL have port enable  input  1  monitor enable.
REQ-008 SHALL have ports evt_valid  output  1, evt_ready  input  1  event output handshake.
REQ-009 SHALL have ports evt_type  output  3 (0 START, 1 RSTART, 2 ADDR, 3 DATA, 4 STOP), evt_data  output  8, evt_ack  output  1.
REQ-010 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-011 SHALL have ports overflow  output  1 (sticky), clr_overflow  input  1, bus_busy  output  1.

Function
REQ-012 SHALL pass scl_i/sda_i through SYNC_STAGES flops; edge detection uses the last stage and one extra history flop.
REQ-013 SHALL detect START as sda falling while scl high; STOP as sda rising while scl high.
REQ-014 SHALL implement FSM IDLE, ADDR, DATA: IDLE->ADDR on START (push START); ADDR/DATA->ADDR on START (push RSTART); ADDR/DATA->IDLE on STOP (push STOP); STOP in IDLE ignored.
REQ-015 SHALL, in ADDR/DATA, shift sda MSB-first on each scl rising edge with a 4-bit counter 0..8; 9th rise samples ACK (sda low -> evt_ack=1), pushes ADDR (in ADDR, then ->DATA) or DATA event with the byte, counter clears.
REQ-016 SHALL clear the bit counter on START/RSTART; STOP event carries evt_data={4'b0,counter value} so a partial byte is reported, evt_ack=0; START/RSTART evt_data=0.
REQ-017 SHALL push the event into the FIFO the cycle after detection; evt_valid asserts the following cycle (detection-to-evt_valid latency 2 pclk cycles with empty FIFO).
REQ-018 SHALL present head entry on evt_type/evt_data/evt_ack while evt_valid=1; pop on evt_valid&&evt_ready; outputs stable while evt_valid&&!evt_ready.
REQ-019 SHALL, on push when full without same-cycle pop, drop the new event and set overflow; full with same-cycle pop accepts the push, no overflow; empty with push and evt_ready pops nothing that cycle.
REQ-020 SHALL hold overflow until clr_overflow=1; set and clear same cycle -> overflow stays 1.
REQ-021 SHALL drive bus_busy=1 in ADDR/DATA, 0 in IDLE.
REQ-022 SHALL, while enable=0, force FSM to IDLE, counter to 0, push nothing; FIFO contents and pops unaffected; monitoring resumes only at next START after enable=1.

Reset
REQ-023 SHALL, on pclk edge with areset=0: sync flops to 1 (idle bus), FSM IDLE, counter 0, FIFO empty, evt_valid 0, evt_type/evt_data/evt_ack 0, fifo_level 0, overflow 0, bus_busy 0; reset mid-transfer discards the partial byte and all queued events without emitting STOP.

Configuration
REQ-024 SHALL, with macro I2C_MASTER_MONITOR_GLITCH_FILTER_EN defined, insert after synchronisation a per-line filter whose output changes only after the input holds a new value for FILT_CYCLES consecutive cycles (adds FILT_CYCLES latency); without the macro the synchronised lines are used directly and FILT_CYCLES is ignored.

Verification
REQ-025 SHALL cover: START, addr 0xA0 ACK, data 0x5A ACK, STOP, evt_ready=1 -> events START; ADDR 0xA0 ack1; DATA 0x5A ack1; STOP data 0x00.
REQ-026 SHALL cover: START, addr 0x51 ACK, RSTART, addr 0x51 NACK, STOP -> START; ADDR 0x51 ack1; RSTART; ADDR 0x51 ack0; STOP.
REQ-027 SHALL cover: FIFO_DEPTH=8, evt_ready=0, 10 events generated -> fifo_level=8, overflow=1, first 8 events drained in order; clr_overflow pulse -> overflow=0.
REQ-028 SHALL cover: STOP after 5 data bits -> STOP event evt_data=0x05, no DATA event.
REQ-029 SHALL cover: areset=0 mid-byte with 3 events queued -> next cycle evt_valid=0, fifo_level=0, bus_busy=0; no STOP emitted.
REQ-030 SHALL cover (macro defined, FILT_CYCLES=3): 2-cycle SDA low pulse while SCL high -> no event; 4-cycle pulse -> START then STOP.
